uart_receiver: RTL and testbench

//  - Receive end of the 32-bit UART link. Deserialises the frame produced by the

---
 rtl/uart_receiver.sv | 146 ++++++++++++++
 tb/tb_uart_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive deserialiser: start, DATA_WIDTH data bits LSB first, parity, stop.
// Define UART_RX_SYNC_EN to pass Rx_dataIn through a 2-flop synchroniser first.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  Baud_Clk,
  input  logic                  Reset,
  input  logic                  Rx_dataIn,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic                  Parity_Err,
  output logic                  Frame_Err,
  output logic                  Rx_Busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  r_rx_par;
  logic                  w_rx_par_nxt;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] w_data_out_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_par_err;
  logic                  w_par_err_nxt;
  logic                  r_frm_err;
  logic                  w_frm_err_nxt;
  logic                  r_busy;
  logic                  w_sample;
  logic                  w_par_bad;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchroniser; both stages idle high so reset never looks like a start bit
  always_ff @(posedge Baud_Clk or posedge Reset) begin
    if (Reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], Rx_dataIn};
    end
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = Rx_dataIn;
`endif

  assign w_par_bad = ((^r_shift) ^ r_rx_par) != PARITY_ODD;

  // Next-state and decision logic
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_rx_par_nxt   = r_rx_par;
    w_data_out_nxt = r_data_out;
    w_valid_nxt    = 1'b0;
    w_par_err_nxt  = 1'b0;
    w_frm_err_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_sample) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        w_shift_nxt[r_bit_cnt] = w_sample;
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = S_PARITY;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        w_rx_par_nxt = w_sample;
        w_state_nxt  = S_STOP;
      end
      S_STOP: begin
        // Decision edge: the word is published even when the frame is bad
        w_data_out_nxt = r_shift;
        w_par_err_nxt  = w_par_bad;
        w_frm_err_nxt  = !w_sample;
        w_valid_nxt    = !w_par_bad && w_sample;
        w_state_nxt    = w_sample ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (w_sample) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Baud_Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_par   <= 1'b0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_par   <= w_rx_par_nxt;
      r_data_out <= w_data_out_nxt;
      r_valid    <= w_valid_nxt;
      r_par_err  <= w_par_err_nxt;
      r_frm_err  <= w_frm_err_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign Data_Out   = r_data_out;
  assign Data_Valid = r_valid;
  assign Parity_Err = r_par_err;
  assign Frame_Err  = r_frm_err;
  assign Rx_Busy    = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: per-cycle comparison against a frame-level
// expectation timeline, plus directed scenarios with literal expectations.
module tb_uart_receiver;

  localparam int DW   = 32;
  localparam int MAXC = 8192;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          Baud_Clk  = 1'b0;
  logic          Reset     = 1'b1;
  logic          Rx_dataIn = 1'b1;
  logic [DW-1:0] Data_Out;
  logic          Data_Valid;
  logic          Parity_Err;
  logic          Frame_Err;
  logic          Rx_Busy;

  uart_receiver #(.DATA_WIDTH(DW), .PARITY_ODD(PODD)) dut (
    .Baud_Clk  (Baud_Clk),
    .Reset     (Reset),
    .Rx_dataIn (Rx_dataIn),
    .Data_Out  (Data_Out),
    .Data_Valid(Data_Valid),
    .Parity_Err(Parity_Err),
    .Frame_Err (Frame_Err),
    .Rx_Busy   (Rx_Busy)
  );

  always #5 Baud_Clk = ~Baud_Clk;

  // cyc = number of rising edges so far; cycle n is the interval after edge n
  int cyc = 0;
  always @(posedge Baud_Clk) cyc <= cyc + 1;

  // Expectation timeline indexed by cycle, filled in when a frame is launched
  bit          exp_valid [MAXC];
  bit          exp_perr  [MAXC];
  bit          exp_ferr  [MAXC];
  bit          exp_busy  [MAXC];
  bit          exp_set   [MAXC];
  logic [31:0] exp_word  [MAXC];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_dout = '0;
  int          valid_count = 0;
  int          perr_count  = 0;
  int          ferr_count  = 0;
  int          valid_cycs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit par_bit(input logic [31:0] d, input bit bad);
    return 1'(($countones(d) % 2)) ^ PODD ^ bad;
  endfunction

  // Per-cycle compare of every output against the timeline
  always @(negedge Baud_Clk) begin
    bit ev, ep, ef, eb;
    bit live;
    live = !Reset && (cyc < MAXC);
    if (Reset) model_dout = '0;
    else if (live && exp_set[cyc]) model_dout = exp_word[cyc];
    ev = live ? exp_valid[cyc] : 1'b0;
    ep = live ? exp_perr[cyc]  : 1'b0;
    ef = live ? exp_ferr[cyc]  : 1'b0;
    eb = live ? exp_busy[cyc]  : 1'b0;
    check("data_out",   Data_Out,             model_dout);
    check("data_valid", {31'b0, Data_Valid},  {31'b0, ev});
    check("parity_err", {31'b0, Parity_Err},  {31'b0, ep});
    check("frame_err",  {31'b0, Frame_Err},   {31'b0, ef});
    check("rx_busy",    {31'b0, Rx_Busy},     {31'b0, eb});
    if (Data_Valid) begin
      valid_count++;
      valid_cycs.push_back(cyc);
    end
    if (Parity_Err) perr_count++;
    if (Frame_Err)  ferr_count++;
  end

  task automatic drive_bit(input bit b);
    Rx_dataIn = b;
    @(negedge Baud_Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  // Launch a full frame from a falling edge; records what the receiver must report
  task automatic send_frame(input logic [31:0] d, input bit bad_par, input bit stop,
                            input int nlow, output int s);
    int p, last;
    bit pb;
    s    = cyc + 1;
    p    = s + LAT + 34;
    pb   = par_bit(d, bad_par);
    last = stop ? (s + LAT + 33) : (s + LAT + 34 + nlow);
    if (p < MAXC) begin
      exp_set[p]   = 1'b1;
      exp_word[p]  = d;
      exp_perr[p]  = bad_par;
      exp_ferr[p]  = !stop;
      exp_valid[p] = !bad_par && stop;
    end
    for (int c = s + LAT; c <= last && c < MAXC; c++) exp_busy[c] = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 32; i++) drive_bit(d[i]);
    drive_bit(pb);
    drive_bit(stop);
    if (!stop) repeat (nlow) drive_bit(1'b0);
  endtask

  initial begin
    int s, s1, s2, v0, p0, f0, sp, gap, nlow;
    logic [31:0] d;
    bit bad, stp;

    // T1: reset held while the line toggles
    repeat (6) begin
      Rx_dataIn = ~Rx_dataIn;
      @(negedge Baud_Clk);
    end
    check("t1_dout", Data_Out, 32'h0);
    check("t1_busy", {31'b0, Rx_Busy}, 32'h0);
    Rx_dataIn = 1'b1;
    #1 Reset = 1'b0;
    @(negedge Baud_Clk);
    idle(3);

    // T2: good frame, pulse on the decision edge 34 edges after the start sample
    v0 = valid_count;
    send_frame(32'hA5A5_0F0F, 1'b0, 1'b1, 0, s);
    idle(40);
    check("t2_valid_count", valid_count, v0 + 1);
    check("t2_valid_cycle", valid_cycs.size() > 0 ? valid_cycs[valid_cycs.size()-1] - s : -1,
          34 + LAT);
    check("t2_dout", Data_Out, 32'hA5A5_0F0F);

    // T3: parity error (even parity of 1 needs parity bit 1; send 0)
    v0 = valid_count; p0 = perr_count;
    send_frame(32'h0000_0001, 1'b1, 1'b1, 0, s);
    idle(40);
    check("t3_perr_count", perr_count, p0 + 1);
    check("t3_no_valid", valid_count, v0);
    check("t3_dout", Data_Out, 32'h0000_0001);

    // T4: framing error followed by a low line; no false start afterwards
    v0 = valid_count; f0 = ferr_count;
    send_frame(32'h1234_5678, 1'b0, 1'b0, 5, s);
    idle(45);
    check("t4_ferr_count", ferr_count, f0 + 1);
    check("t4_no_valid", valid_count, v0);
    check("t4_busy_after", {31'b0, Rx_Busy}, 32'h0);

    // T5: back-to-back frames
    v0 = valid_count;
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b1, 0, s1);
    send_frame(32'h8000_0000, 1'b0, 1'b1, 0, s2);
    idle(40);
    check("t5_valid_count", valid_count, v0 + 2);
    sp = (valid_cycs.size() >= 2) ?
         valid_cycs[valid_cycs.size()-1] - valid_cycs[valid_cycs.size()-2] : -1;
    check("t5_spacing", sp, 35);
    check("t5_dout", Data_Out, 32'h8000_0000);

    // T6: reset after 10 data bits, then a clean frame
    v0 = valid_count;
    s = cyc + 1;
    for (int c = s + LAT; c <= s + 10; c++) exp_busy[c] = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 10; i++) drive_bit(1'($urandom_range(0, 1)));
    #2 Reset = 1'b1;
    Rx_dataIn = 1'b1;
    @(negedge Baud_Clk);
    check("t6_busy_in_reset", {31'b0, Rx_Busy}, 32'h0);
    @(negedge Baud_Clk);
    #1 Reset = 1'b0;
    @(negedge Baud_Clk);
    idle(3);
    send_frame(32'hDEAD_BEEF, 1'b0, 1'b1, 0, s);
    idle(40);
    check("t6_valid_count", valid_count, v0 + 1);
    check("t6_dout", Data_Out, 32'hDEAD_BEEF);

    // Randomised frames: mixed parity errors, framing errors, gaps and back-to-back
    repeat (40) begin
      d    = $urandom;
      bad  = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 4) != 0);
      nlow = $urandom_range(0, 4);
      send_frame(d, bad, stp, nlow, s);
      gap = stp ? $urandom_range(0, 3) : $urandom_range(1, 3);
      idle(gap);
    end
    idle(45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
